count_sched: RTL
================

Name: count_sched

Overview:
- Scheduler that time-shares one up-counter between NUM_REQ requesters.
- Round-robin arbitration picks one requester, loads its terminal count, and runs the counter from 0 up to that value.
- Signals completion with a done pulse and the winner's index, then releases the counter.
- Sits between requesting blocks and the shared count resource. It owns the count register, and the enable/clear sequencing of that register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, counter width in bits
- IDW, 2, width of requester index; must be at least clog2(NUM_REQ)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous active-low reset
- req  input  NUM_REQ  per-requester level request
- len  input  NUM_REQ*WIDTH  per-requester terminal count; slice i is len[i*WIDTH +: WIDTH]
- abort  input  1  cancel the current run
- grant  output  NUM_REQ  one-hot owner of the counter; 0 when idle
- busy  output  1  high in RUN or DONE
- count  output  WIDTH  current shared count value
- done  output  1  one-cycle completion pulse
- done_id  output  IDW  index of the requester that completed; valid while done=1

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - grant=0, busy=0, count=0, done=0, done_id=0.
  - Round-robin pointer is set so requester 0 has top priority.
  - Reset overrides every other input, including mid-run. No done is produced for an interrupted run.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, select the first set bit searching upward from ptr+1, wrapping modulo NUM_REQ. After reset, the search starts at 0.
  - On the same edge: grant<=onehot(winner), latch term<=len slice of winner, count<=0, state<=RUN.
  - Grant appears one cycle after req is sampled.
  - If req==0, stay in IDLE; count holds its last value.
- RUN:
  - If abort==1: state<=IDLE, grant<=0, count<=0, no done, ptr<=winner. abort has priority over terminal detection.
  - Else if count==term: state<=DONE, done<=1, done_id<=winner, count holds.
  - Else: count<=count+1.
  - len and req changes during RUN are ignored. A requester dropping req does not cancel its run.
- DONE:
  - Lasts exactly one cycle with done=1 and grant still asserted.
  - Next edge: state<=IDLE, grant<=0, done<=0, ptr<=winner. count holds term until the next grant clears it.
  - abort in DONE is ignored.
- Latency for len=L, counting grant-high cycles:
  - RUN lasts L+1 cycles (count 0..L), then DONE lasts 1 cycle, so grant is high for L+2 cycles.
  - At least one IDLE cycle separates consecutive grants.
- len=0: RUN lasts one cycle with count=0, then DONE.
- len=2^WIDTH-1: count reaches all-ones and never wraps. Terminal detection precedes increment.
- Fairness: a continuously requesting set is served in strict rotation. No requester is granted twice while another requests.
- Invariants:
  - grant is one-hot or zero.
  - busy==(grant!=0).
  - done implies busy.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles with req=4'b1111. Release with req=0. Required: grant=0, count=0, done=0 throughout; FSM stays in IDLE.
2. Single run: req=4'b0010, len[1]=3. Required:
   - grant=4'b0010 one cycle after req.
   - count steps 0,1,2,3.
   - done=1 with done_id=1 on the cycle after count first equals 3.
   - grant high for exactly 5 cycles, then 0.
3. Round robin: req=4'b1111 held, all len=0. Required:
   - Grants in order 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts 2 cycles, with one idle cycle between grants.
   - done_id sequence is 0,1,2,3,0.
4. Abort: req=4'b0100, len[2]=9, abort pulsed when count==4. Required:
   - Next cycle grant=0, count=0, no done.
   - Next arbitration starts searching from index 3; with req=4'b0101 held, requester 0 wins.
5. Max length: len[0]=15, WIDTH=4. Required: count reaches 15, done fires, count does not wrap to 0 before release.
6. Reset mid-run: assert reset=0 at count==2 during a len=7 run. Required: next cycle grant=0, count=0, done=0, and requester 0 has top priority again.

Source files
------------

// File: rtl/count_sched.sv
// Round-robin scheduler that time-shares one up-counter between NUM_REQ requesters.
// The winner's terminal count is latched, the counter runs 0..term, then done pulses with the winner id.
module count_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] len,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [WIDTH-1:0]         count,
    output logic                     done,
    output logic [IDW-1:0]           done_id
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       winner_q, winner_d;
    logic [IDW-1:0]       done_id_q, done_id_d;
    logic [WIDTH-1:0]     term_q, term_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 found;
    logic [IDW-1:0]       pick;
    int                   idx;

    // Search upward from ptr+1, wrapping; ptr holds the most recently served requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        done_id_d = done_id_q;
        term_d    = term_q;
        count_d   = count_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = RUN;
                    winner_d = pick;
                    grant_d  = NUM_REQ'(1) << pick;
                    term_d   = len[int'(pick)*WIDTH +: WIDTH];
                    count_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = winner_q;
                end else if (count_q == term_q) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = winner_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = winner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NUM_REQ - 1);
            winner_q  <= '0;
            done_id_q <= '0;
            term_q    <= '0;
            count_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            winner_q  <= winner_d;
            done_id_q <= done_id_d;
            term_q    <= term_d;
            count_q   <= count_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign count   = count_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule
